// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the global clock-gate sequencer and its
// profiling counters.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUNNING  = 2'd0,
        ST_STOPPING = 2'd1,
        ST_STOPPED  = 2'd2,
        ST_RESUMING = 2'd3
    } gate_state_e;

    localparam int SETTLE_CYCLES_DEFAULT = 3;
    localparam int PROF_CNT_W            = 32;
    localparam int SETTLE_CNT_W          = $clog2(SETTLE_CYCLES_DEFAULT + 1);

    // Width of a down-counter able to hold settle_cycles-1; never below 1 bit.
    function automatic int settle_cnt_width(input int settle_cycles);
        return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/clock_gate_controller_prof_counter.sv
// Profiling counter with synchronous clear (wins over increment) and an
// optional saturate-at-all-ones mode; otherwise it wraps.
module prof_counter
    import clock_ctrl_pkg::*;
#(
    parameter int CNT_W    = PROF_CNT_W,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !(SATURATE && at_max)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/clock_gate_controller.sv
// Sequences the active-low CE of the glitchless core clock-gating buffer from
// level stop requests; runs on the free-running source clock.
module clock_gate_controller
    import clock_ctrl_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
    parameter int CNT_W         = PROF_CNT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] stop_req,
    output logic [NUM_REQ-1:0] stop_ack,
    output logic               ce_n,
    output logic               gated,
    input  logic               counter_clear,
    output logic [CNT_W-1:0]   gated_cycles,
    output logic [CNT_W-1:0]   stop_events,
    output logic [1:0]         dbg_state
);

    localparam int            SW          = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);

    localparam logic [1:0] RUNNING  = ST_RUNNING;
    localparam logic [1:0] STOPPING = ST_STOPPING;
    localparam logic [1:0] STOPPED  = ST_STOPPED;
    localparam logic [1:0] RESUMING = ST_RESUMING;

    logic [1:0]         state_q, state_d;
    logic [SW-1:0]      settle_q, settle_d;
    logic               ce_n_q, ce_n_d;
    logic               gated_q, gated_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               any_req;
    logic               stop_event;

    assign any_req    = |stop_req;
    assign stop_event = (state_q == RUNNING) && any_req;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        ce_n_d   = 1'b0;
        ack_d    = '0;
        case (state_q)
            RUNNING: begin
                if (any_req) begin
                    state_d  = STOPPING;
                    settle_d = SETTLE_LOAD;
                    ce_n_d   = 1'b1;
                end
            end
            STOPPING: begin
                ce_n_d = 1'b1;
                if (settle_q == '0) begin
                    if (any_req) begin
                        state_d = STOPPED;
                        ack_d   = stop_req;
                    end else begin
                        // Every requester withdrew while the buffer settled.
                        state_d  = RESUMING;
                        settle_d = SETTLE_LOAD;
                        ce_n_d   = 1'b0;
                    end
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            STOPPED: begin
                if (any_req) begin
                    ce_n_d = 1'b1;
                    ack_d  = stop_req;
                end else begin
                    state_d  = RESUMING;
                    settle_d = SETTLE_LOAD;
                end
            end
            RESUMING: begin
                if (settle_q == '0) begin
                    state_d = RUNNING;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            default: begin
                state_d = RUNNING;
            end
        endcase
    end

    assign gated_d = (state_d != RUNNING);

    // Async reset drops ce_n straight away so the core clock resumes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= RUNNING;
            settle_q <= '0;
            ce_n_q   <= 1'b0;
            gated_q  <= 1'b0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ce_n_q   <= ce_n_d;
            gated_q  <= gated_d;
            ack_q    <= ack_d;
        end
    end

    prof_counter #(.CNT_W(CNT_W), .SATURATE(1'b1)) u_gated_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (ce_n_q),
        .clear_i (counter_clear),
        .count_o (gated_cycles)
    );

    prof_counter #(.CNT_W(CNT_W), .SATURATE(1'b0)) u_event_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .inc_i   (stop_event),
        .clear_i (counter_clear),
        .count_o (stop_events)
    );

    assign ce_n      = ce_n_q;
    assign gated     = gated_q;
    assign stop_ack  = ack_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_clock_gate_controller.sv
// Scenario bench for clock_gate_controller: expected {ce_n, gated, stop_ack}
// vectors are queued as stimulus is driven and popped after the due edge.
module tb_clock_gate_controller;

    localparam int NR = 4;
    localparam int SC = 3;
    localparam int CW = 4;
    localparam int W  = NR + 2;

    localparam logic [1:0] S_RUNNING  = 2'd0;
    localparam logic [1:0] S_STOPPING = 2'd1;
    localparam logic [1:0] S_STOPPED  = 2'd2;
    localparam logic [1:0] S_RESUMING = 2'd3;

    logic          clock;
    logic          reset;
    logic [NR-1:0] stop_req;
    logic [NR-1:0] stop_ack;
    logic          ce_n;
    logic          gated;
    logic          counter_clear;
    logic [CW-1:0] gated_cycles;
    logic [CW-1:0] stop_events;
    logic [1:0]    dbg_state;

    logic [W-1:0]  exp_q[$];
    int            vectors;
    int            miscompares;

    // Reference model of the profiling counters.
    logic [CW-1:0] gc_exp;
    logic [CW-1:0] se_exp;
    logic          ce_prev;

    clock_gate_controller #(
        .NUM_REQ(NR), .SETTLE_CYCLES(SC), .CNT_W(CW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stop_req      (stop_req),
        .stop_ack      (stop_ack),
        .ce_n          (ce_n),
        .gated         (gated),
        .counter_clear (counter_clear),
        .gated_cycles  (gated_cycles),
        .stop_events   (stop_events),
        .dbg_state     (dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One active edge; updates the counter model with the ce_n in force
    // before the edge, then leaves time 1 unit past the edge for checking.
    task automatic step(input logic ce_after, input logic ev);
        @(posedge clock);
        if (counter_clear) begin
            gc_exp = '0;
            se_exp = '0;
        end else begin
            if (ce_prev && gc_exp != {CW{1'b1}}) gc_exp = gc_exp + 1'b1;
            if (ev) se_exp = se_exp + 1'b1;
        end
        ce_prev = ce_after;
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        reset = 1'b1; stop_req = '0; counter_clear = 1'b0;
        gc_exp = '0; se_exp = '0; ce_prev = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        exp_q.push_back({1'b0, 1'b0, {NR{1'b0}}});
        exp = exp_q.pop_front(); vectors++;
        if ({ce_n, gated, stop_ack} !== exp) begin
            miscompares++; $display("FAIL reset_outputs: got %b want %b", {ce_n, gated, stop_ack}, exp);
        end
        vectors++;
        if (gated_cycles !== 0 || stop_events !== 0 || dbg_state !== S_RUNNING) begin
            miscompares++; $display("FAIL reset_counters: got gc=%0d se=%0d st=%0d want 0 0 0", gated_cycles, stop_events, dbg_state);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, 1'b0, {NR{1'b0}}});
            step(1'b0, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp) begin
                miscompares++; $display("FAIL idle_after_reset: got %b want %b", {ce_n, gated, stop_ack}, exp);
            end
        end
    endtask

    task automatic test_stop_entry();
        logic [W-1:0] exp;
        stop_req = 4'b0001;
        exp_q.push_back({1'b1, 1'b1, 4'b0000});
        step(1'b1, 1'b1);
        exp = exp_q.pop_front(); vectors++;
        if ({ce_n, gated, stop_ack} !== exp || stop_events !== se_exp) begin
            miscompares++; $display("FAIL stop_edge: got %b se=%0d want %b se=%0d", {ce_n, gated, stop_ack}, stop_events, exp, se_exp);
        end
        for (int i = 1; i <= SC; i++) begin
            exp_q.push_back({1'b1, 1'b1, (i == SC) ? 4'b0001 : 4'b0000});
            step(1'b1, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp || gated_cycles !== gc_exp) begin
                miscompares++; $display("FAIL stop_settle[%0d]: got %b gc=%0d want %b gc=%0d", i, {ce_n, gated, stop_ack}, gated_cycles, exp, gc_exp);
            end
        end
        vectors++;
        if (dbg_state !== S_STOPPED) begin
            miscompares++; $display("FAIL stop_state: got %0d want %0d", dbg_state, S_STOPPED);
        end
    endtask

    task automatic test_late_join();
        logic [W-1:0] exp;
        logic [NR-1:0] reqs [2];
        reqs[0] = 4'b0101;
        reqs[1] = 4'b0100;
        for (int i = 0; i < 2; i++) begin
            stop_req = reqs[i];
            exp_q.push_back({1'b1, 1'b1, reqs[i]});
            step(1'b1, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp || gated_cycles !== gc_exp) begin
                miscompares++; $display("FAIL late_join[%0d]: got %b gc=%0d want %b gc=%0d", i, {ce_n, gated, stop_ack}, gated_cycles, exp, gc_exp);
            end
        end
    endtask

    task automatic test_resume_rerequest();
        logic [W-1:0] exp;
        stop_req = '0;
        exp_q.push_back({1'b0, 1'b1, 4'b0000});
        step(1'b0, 1'b0);
        exp = exp_q.pop_front(); vectors++;
        if ({ce_n, gated, stop_ack} !== exp || dbg_state !== S_RESUMING) begin
            miscompares++; $display("FAIL resume_edge: got %b st=%0d want %b st=%0d", {ce_n, gated, stop_ack}, dbg_state, exp, S_RESUMING);
        end
        stop_req = 4'b0010;
        for (int i = 1; i <= SC; i++) begin
            exp_q.push_back({1'b0, (i < SC), 4'b0000});
            step(1'b0, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp) begin
                miscompares++; $display("FAIL resume_ignore[%0d]: got %b want %b", i, {ce_n, gated, stop_ack}, exp);
            end
        end
        vectors++;
        if (dbg_state !== S_RUNNING) begin
            miscompares++; $display("FAIL resume_running: got %0d want %0d", dbg_state, S_RUNNING);
        end
        exp_q.push_back({1'b1, 1'b1, 4'b0000});
        step(1'b1, 1'b1);
        for (int i = 1; i <= SC; i++) begin
            exp_q.push_back({1'b1, 1'b1, (i == SC) ? 4'b0010 : 4'b0000});
            step(1'b1, 1'b0);
        end
        for (int i = 0; i <= SC; i++) begin
            exp = exp_q.pop_front(); vectors++;
            if (i == SC && ({ce_n, gated, stop_ack} !== exp || stop_events !== se_exp)) begin
                miscompares++; $display("FAIL rerequest_ack: got %b se=%0d want %b se=%0d", {ce_n, gated, stop_ack}, stop_events, exp, se_exp);
            end
        end
        stop_req = '0;
        step(1'b0, 1'b0);
        for (int i = 0; i < SC; i++) step(1'b0, 1'b0);
        vectors++;
        if (dbg_state !== S_RUNNING || ce_n !== 1'b0) begin
            miscompares++; $display("FAIL release_running: got st=%0d ce_n=%b want %0d 0", dbg_state, ce_n, S_RUNNING);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] exp;
        stop_req = 4'b0001;
        step(1'b1, 1'b1);
        stop_req = '0;
        for (int i = 1; i < SC; i++) begin
            exp_q.push_back({1'b1, 1'b1, 4'b0000});
            step(1'b1, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp) begin
                miscompares++; $display("FAIL abort_settle[%0d]: got %b want %b", i, {ce_n, gated, stop_ack}, exp);
            end
        end
        exp_q.push_back({1'b0, 1'b1, 4'b0000});
        step(1'b0, 1'b0);
        exp = exp_q.pop_front(); vectors++;
        if ({ce_n, gated, stop_ack} !== exp || dbg_state !== S_RESUMING) begin
            miscompares++; $display("FAIL abort_resume: got %b st=%0d want %b st=%0d", {ce_n, gated, stop_ack}, dbg_state, exp, S_RESUMING);
        end
        for (int i = 1; i <= SC; i++) begin
            exp_q.push_back({1'b0, (i < SC), 4'b0000});
            step(1'b0, 1'b0);
            exp = exp_q.pop_front(); vectors++;
            if ({ce_n, gated, stop_ack} !== exp) begin
                miscompares++; $display("FAIL abort_return[%0d]: got %b want %b", i, {ce_n, gated, stop_ack}, exp);
            end
        end
        vectors++;
        if (dbg_state !== S_RUNNING || stop_events !== se_exp || gated_cycles !== gc_exp) begin
            miscompares++; $display("FAIL abort_counters: got st=%0d se=%0d gc=%0d want %0d %0d %0d", dbg_state, stop_events, gated_cycles, S_RUNNING, se_exp, gc_exp);
        end
    endtask

    task automatic test_async_reset();
        logic [W-1:0] exp;
        stop_req = 4'b1000;
        step(1'b1, 1'b1);
        for (int i = 0; i < SC; i++) step(1'b1, 1'b0);
        vectors++;
        if (stop_ack !== 4'b1000 || dbg_state !== S_STOPPED) begin
            miscompares++; $display("FAIL pre_reset_stopped: got ack=%b st=%0d want 1000 %0d", stop_ack, dbg_state, S_STOPPED);
        end
        #2;
        reset = 1'b1;
        gc_exp = '0; se_exp = '0; ce_prev = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 4'b0000});
        #1;
        exp = exp_q.pop_front(); vectors++;
        if ({ce_n, gated, stop_ack} !== exp) begin
            miscompares++; $display("FAIL async_reset_outputs: got %b want %b", {ce_n, gated, stop_ack}, exp);
        end
        vectors++;
        if (gated_cycles !== 0 || stop_events !== 0) begin
            miscompares++; $display("FAIL async_reset_counters: got gc=%0d se=%0d want 0 0", gated_cycles, stop_events);
        end
        stop_req = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b0);
        vectors++;
        if (dbg_state !== S_RUNNING || ce_n !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_state: got st=%0d ce_n=%b want %0d 0", dbg_state, ce_n, S_RUNNING);
        end
    endtask

    task automatic test_saturate_clear();
        stop_req = 4'b0001;
        step(1'b1, 1'b1);
        for (int i = 0; i < 20 + SC; i++) begin
            step(1'b1, 1'b0);
            vectors++;
            if (gated_cycles !== gc_exp) begin
                miscompares++; $display("FAIL saturate[%0d]: got %0d want %0d", i, gated_cycles, gc_exp);
            end
        end
        vectors++;
        if (gated_cycles !== 4'd15) begin
            miscompares++; $display("FAIL saturate_final: got %0d want 15", gated_cycles);
        end
        counter_clear = 1'b1;
        step(1'b1, 1'b0);
        counter_clear = 1'b0;
        vectors++;
        if (gated_cycles !== 0 || stop_events !== 0) begin
            miscompares++; $display("FAIL clear_stopped: got gc=%0d se=%0d want 0 0", gated_cycles, stop_events);
        end
        step(1'b1, 1'b0);
        vectors++;
        if (gated_cycles !== gc_exp) begin
            miscompares++; $display("FAIL count_after_clear: got %0d want %0d", gated_cycles, gc_exp);
        end
        stop_req = '0;
        step(1'b0, 1'b0);
        for (int i = 0; i < SC; i++) step(1'b0, 1'b0);
        stop_req = 4'b0001;
        counter_clear = 1'b1;
        step(1'b1, 1'b1);
        counter_clear = 1'b0;
        vectors++;
        if (stop_events !== 0 || gated_cycles !== 0 || ce_n !== 1'b1) begin
            miscompares++; $display("FAIL clear_vs_event: got se=%0d gc=%0d ce_n=%b want 0 0 1", stop_events, gated_cycles, ce_n);
        end
        step(1'b1, 1'b0);
        vectors++;
        if (stop_events !== se_exp || gated_cycles !== gc_exp) begin
            miscompares++; $display("FAIL after_clear_event: got se=%0d gc=%0d want %0d %0d", stop_events, gated_cycles, se_exp, gc_exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_stop_entry();
        test_late_join();
        test_resume_rerequest();
        test_abort();
        test_async_reset();
        test_saturate_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
